// File: rtl/ysyx_lsu_pkg.sv
// Shared encodings for the load/store unit: access selects, FSM states and
// the default abort budget for an unanswered memory access.
package ysyx_lsu_pkg;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_LB   = 3'b001;
    localparam logic [2:0] RD_LBU  = 3'b010;
    localparam logic [2:0] RD_LH   = 3'b011;
    localparam logic [2:0] RD_LHU  = 3'b100;
    localparam logic [2:0] RD_LW   = 3'b101;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_SB   = 2'b01;
    localparam logic [1:0] WR_SH   = 2'b10;
    localparam logic [1:0] WR_SW   = 2'b11;

    localparam int unsigned LSU_TIMEOUT = 256;
    localparam int unsigned LSU_CNT_W   = $clog2(LSU_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/ysyx_lsu_align.sv
// Combinational datapath of the LSU: request legality, store lane placement
// and load byte/half extraction with sign or zero extension.
module ysyx_lsu_align (
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_rd_sel_i,
    input  logic [1:0]  req_wr_sel_i,
    output logic        req_err_o,
    output logic        req_nop_o,
    output logic        req_wen_o,
    output logic [31:0] req_wdata_o,
    output logic [3:0]  req_wmask_o,
    input  logic [1:0]  ld_off_i,
    input  logic [2:0]  ld_sel_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);
    import ysyx_lsu_pkg::*;

    logic       is_half_s;
    logic       is_word_s;
    logic [7:0] ld_byte_s;
    logic [15:0] ld_half_s;

    // Legality check and store lane replication for the incoming request
    always_comb begin
        is_half_s = (req_rd_sel_i == RD_LH) || (req_rd_sel_i == RD_LHU) || (req_wr_sel_i == WR_SH);
        is_word_s = (req_rd_sel_i == RD_LW) || (req_wr_sel_i == WR_SW);
        req_nop_o = (req_rd_sel_i == RD_NONE) && (req_wr_sel_i == WR_NONE);
        req_err_o = (req_rd_sel_i[2] && req_rd_sel_i[1])
                  || ((req_rd_sel_i != RD_NONE) && (req_wr_sel_i != WR_NONE))
                  || (is_half_s && req_off_i[0])
                  || (is_word_s && (req_off_i != 2'b00));
        req_wen_o   = 1'b0;
        req_wdata_o = 32'h0000_0000;
        req_wmask_o = 4'b0000;
        // An errored request is never presented to memory, so its lanes stay idle
        if (req_err_o) begin
            req_wen_o = 1'b0;
        end else begin
            case (req_wr_sel_i)
                WR_SB: begin
                    req_wen_o   = 1'b1;
                    req_wdata_o = {4{req_wdata_i[7:0]}};
                    req_wmask_o = 4'b0001 << req_off_i;
                end
                WR_SH: begin
                    req_wen_o   = 1'b1;
                    req_wdata_o = {2{req_wdata_i[15:0]}};
                    req_wmask_o = 4'b0011 << req_off_i;
                end
                WR_SW: begin
                    req_wen_o   = 1'b1;
                    req_wdata_o = req_wdata_i;
                    req_wmask_o = 4'b1111;
                end
                default: begin
                    req_wen_o = 1'b0;
                end
            endcase
        end
    end

    // Load lane extraction; stores and nops yield zero
    always_comb begin
        ld_byte_s = ld_word_i[{ld_off_i, 3'b000} +: 8];
        ld_half_s = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (ld_sel_i)
            RD_LB:   ld_data_o = {{24{ld_byte_s[7]}}, ld_byte_s};
            RD_LBU:  ld_data_o = {24'h00_0000, ld_byte_s};
            RD_LH:   ld_data_o = {{16{ld_half_s[15]}}, ld_half_s};
            RD_LHU:  ld_data_o = {16'h0000, ld_half_s};
            RD_LW:   ld_data_o = ld_word_i;
            default: ld_data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: accepts one execute request at a time and runs it as a
// valid/ready memory transaction with a bounded wait for the response.
module ysyx_lsu
    import ysyx_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_rd_sel,
    input  logic [1:0]        req_wr_sel,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_rdata
);
    localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        rd_sel_q, rd_sel_d;
    logic              wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic        a_err_s, a_nop_s, a_wen_s;
    logic [31:0] a_wdata_s, a_ld_s;
    logic [3:0]  a_wmask_s;

    ysyx_lsu_align u_align (
        .req_off_i    (req_addr[1:0]),
        .req_wdata_i  (req_wdata),
        .req_rd_sel_i (req_rd_sel),
        .req_wr_sel_i (req_wr_sel),
        .req_err_o    (a_err_s),
        .req_nop_o    (a_nop_s),
        .req_wen_o    (a_wen_s),
        .req_wdata_o  (a_wdata_s),
        .req_wmask_o  (a_wmask_s),
        .ld_off_i     (off_q),
        .ld_sel_i     (rd_sel_q),
        .ld_word_i    (mem_rdata),
        .ld_data_o    (a_ld_s)
    );

    // State and latched request/result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            off_q    <= 2'b00;
            rd_sel_q <= 3'b000;
            wen_q    <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            wmask_q  <= 4'b0000;
            cnt_q    <= '0;
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            rd_sel_q <= rd_sel_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic for the request/memory/response sequence
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        off_d    = off_q;
        rd_sel_d = rd_sel_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = {req_addr[ADDR_W-1:2], 2'b00};
                    off_d    = req_addr[1:0];
                    rd_sel_d = req_rd_sel;
                    wen_d    = a_wen_s;
                    wdata_d  = a_wdata_s;
                    wmask_d  = a_wmask_s;
                    rdata_d  = 32'h0000_0000;
                    err_d    = a_err_s;
                    cnt_d    = '0;
                    state_d  = (a_err_s || a_nop_s) ? ST_RESP : ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // Store acks land here too; their extracted data is zero
                if (mem_resp_valid) begin
                    rdata_d = a_ld_s;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ);
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu: hand-computed loads, stores, errors, stalls,
// timeout abort and reset during an outstanding access.
module tb_ysyx_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_rd_sel;
    logic [1:0]  req_wr_sel;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ysyx_lsu #(.ADDR_W(32), .TIMEOUT(256)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd_sel     (req_rd_sel),
        .req_wr_sel     (req_wr_sel),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] rd, input logic [1:0] wr);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd_sel = rd;
        req_wr_sel = wr;
    endtask

    // Zero-wait access: accept in cycle 0, memory request in 1, response in 2, result in 3
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] mrd,
                           input logic [31:0] exp_maddr, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_mask, input logic [31:0] exp_rdata);
        logic exp_wen;
        exp_wen = (wr != 2'b00);
        drive_req(addr, wdata, rd, wr);
        chk({tag, ".c0_rdy"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk({tag, ".c1_ctl"}, 32'({mem_req_valid, resp_valid, req_ready}), 32'b100);
        chk({tag, ".c1_addr"}, mem_addr, exp_maddr);
        chk({tag, ".c1_wen_mask"}, 32'({mem_wen, mem_wmask}), 32'({exp_wen, exp_mask}));
        if (exp_wen) chk({tag, ".c1_wdata"}, mem_wdata, exp_wdata);
        tick();
        chk({tag, ".c2_ctl"}, 32'({mem_req_valid, resp_valid}), 32'b00);
        mem_resp_valid = 1'b1;
        mem_rdata      = mrd;
        tick();
        mem_resp_valid = 1'b0;
        chk({tag, ".c3_valid_err"}, 32'({resp_valid, resp_err}), 32'b10);
        chk({tag, ".c3_rdata"}, resp_rdata, exp_rdata);
        tick();
        chk({tag, ".c4_idle"}, 32'({req_ready, resp_valid}), 32'b10);
    endtask

    // Errored or nop request: result in cycle 1, memory never requested
    task automatic run_short(input string tag, input logic [31:0] addr,
                             input logic [2:0] rd, input logic [1:0] wr, input logic exp_err);
        drive_req(addr, 32'hFFFF_FFFF, rd, wr);
        tick();
        req_valid = 1'b0;
        chk({tag, ".c1_ctl"}, 32'({resp_valid, mem_req_valid, resp_err, req_ready}),
            32'({1'b1, 1'b0, exp_err, 1'b0}));
        chk({tag, ".c1_rdata"}, resp_rdata, 32'h0000_0000);
        tick();
        chk({tag, ".c2_idle"}, 32'({req_ready, mem_req_valid, resp_valid}), 32'b100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_rd_sel = 3'b000; req_wr_sel = 2'b00;
        resp_ready = 1'b1; mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        chk("rst.ctl", 32'({req_ready, resp_valid, resp_err, mem_req_valid, mem_wen, mem_wmask}),
            32'b1_0000_0000);
        chk("rst.addr", mem_addr, 32'h0);
        chk("rst.wdata", mem_wdata, 32'h0);
        chk("rst.rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        tick();

        run_txn("lb3",  32'h8000_0003, 32'h0, 3'b001, 2'b00, 32'h80FF_1234, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80);
        run_txn("lbu1", 32'h8000_0001, 32'h0, 3'b010, 2'b00, 32'h80FF_1234, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_0012);
        run_txn("lhu2", 32'h8000_0002, 32'h0, 3'b100, 2'b00, 32'hBEEF_0000, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_BEEF);
        run_txn("lh2",  32'h8000_0002, 32'h0, 3'b011, 2'b00, 32'hBEEF_0000, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_BEEF);
        run_txn("lh0",  32'h8000_0008, 32'h0, 3'b011, 2'b00, 32'h1234_8001, 32'h8000_0008, 32'h0, 4'b0000, 32'hFFFF_8001);
        run_txn("lw",   32'h8000_0004, 32'h0, 3'b101, 2'b00, 32'hCAFE_F00D, 32'h8000_0004, 32'h0, 4'b0000, 32'hCAFE_F00D);
        run_txn("sh2",  32'h8000_0002, 32'h0000_ABCD, 3'b000, 2'b10, 32'hDEAD_BEEF, 32'h8000_0000, 32'hABCD_ABCD, 4'b1100, 32'h0);
        run_txn("sb1",  32'h8000_0001, 32'h1234_56A5, 3'b000, 2'b01, 32'hDEAD_BEEF, 32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 32'h0);
        run_txn("sw",   32'h8000_000C, 32'h1357_9BDF, 3'b000, 2'b11, 32'hDEAD_BEEF, 32'h8000_000C, 32'h1357_9BDF, 4'b1111, 32'h0);

        run_short("sw_mis",  32'h8000_0001, 3'b000, 2'b11, 1'b1);
        run_short("rd110",   32'h8000_0000, 3'b110, 2'b00, 1'b1);
        run_short("rd111",   32'h8000_0000, 3'b111, 2'b00, 1'b1);
        run_short("lh_mis",  32'h8000_0001, 3'b011, 2'b00, 1'b1);
        run_short("lw_mis",  32'h8000_0002, 3'b101, 2'b00, 1'b1);
        run_short("sh_mis",  32'h8000_0003, 3'b000, 2'b10, 1'b1);
        run_short("both",    32'h8000_0000, 3'b101, 2'b11, 1'b1);
        run_short("nop",     32'h8000_0000, 3'b000, 2'b00, 1'b0);

        // Memory back-pressure for 5 cycles, write-back back-pressure for 3
        drive_req(32'h8000_0010, 32'h1234_5678, 3'b000, 2'b11);
        mem_req_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall.ctl", 32'({mem_req_valid, mem_wen, mem_wmask, req_ready}), 32'b1_1_1111_0);
            chk("stall.addr", mem_addr, 32'h8000_0010);
            chk("stall.wdata", mem_wdata, 32'h1234_5678);
            tick();
        end
        mem_req_ready = 1'b1;
        chk("stall.last", 32'(mem_req_valid), 32'd1);
        tick();
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        resp_ready = 1'b0;
        tick();
        mem_resp_valid = 1'b0;
        drive_req(32'h8000_0000, 32'h0, 3'b101, 2'b00);
        for (int i = 0; i < 3; i++) begin
            chk("hold.ctl", 32'({resp_valid, req_ready, resp_err, mem_req_valid}), 32'b1000);
            chk("hold.rdata", resp_rdata, 32'h0);
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        chk("hold.last", 32'(resp_valid), 32'd1);
        tick();
        chk("hold.idle", 32'({req_ready, resp_valid, mem_req_valid}), 32'b100);
        tick();
        chk("hold.noaccept", 32'({req_ready, mem_req_valid}), 32'b10);

        // Unanswered load: 256 cycles in WAIT, then error
        drive_req(32'h8000_0020, 32'h0, 3'b101, 2'b00);
        tick();
        req_valid = 1'b0;
        tick();
        n = 0;
        while (!resp_valid && n < 400) begin
            tick();
            n++;
        end
        chk("to.latency", 32'(n), 32'd256);
        chk("to.err", 32'({resp_valid, resp_err}), 32'b11);
        chk("to.rdata", resp_rdata, 32'h0);
        tick();
        chk("to.idle", 32'(req_ready), 32'd1);

        // Reset while waiting on memory, then a stray response
        run_txn("pre", 32'h8000_0040, 32'h0, 3'b101, 2'b00, 32'h0BAD_F00D, 32'h8000_0040, 32'h0, 4'b0000, 32'h0BAD_F00D);
        drive_req(32'h8000_0044, 32'h0, 3'b101, 2'b00);
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("mrst.ctl", 32'({req_ready, resp_valid, resp_err, mem_req_valid, mem_wen, mem_wmask}),
            32'b1_0000_0000);
        chk("mrst.addr", mem_addr, 32'h0);
        chk("mrst.rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_resp_valid = 1'b0;
        chk("stray.ctl", 32'({req_ready, resp_valid, mem_req_valid}), 32'b100);
        chk("stray.rdata", resp_rdata, 32'h0);
        run_txn("post", 32'h8000_0004, 32'h0, 3'b101, 2'b00, 32'hCAFE_F00D, 32'h8000_0004, 32'h0, 4'b0000, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_lsu.md
Name: ysyx_lsu

Overview:
Load/store unit directly downstream of the execute stage. It takes the effective address (ALU result), store data (rs2) and the access-type selects produced by execute, and runs one data-memory transaction per request over a valid/ready memory port. It returns sign/zero-extended load data, or a store acknowledge, to the register write-back mux. It replaces single-cycle direct memory calls with a multi-cycle handshake, and detects misaligned and illegal accesses.

Parameters:
ADDR_W, 32, address width (data width fixed at 32)
TIMEOUT, 256, max cycles in WAIT before the access is aborted with error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  execute presents a request
req_ready  out  1  LSU can accept (IDLE only)
req_addr  in  ADDR_W  byte effective address
req_wdata  in  32  store data (rs2)
req_rd_sel  in  3  000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110/111 illegal
req_wr_sel  in  2  00 none, 01 SB, 10 SH, 11 SW
resp_valid  out  1  result available
resp_ready  in  1  write-back accepts result
resp_rdata  out  32  extended load data; 0 for stores, nop and errors
resp_err  out  1  misaligned, illegal or timeout
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  word-aligned address, req_addr with [1:0] cleared
mem_wen  out  1  1 = write
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte-lane enables
mem_resp_valid  in  1  read data valid / write ack
mem_rdata  in  32  full word read

Behaviour:
- Reset: clk and rst only; rst is asynchronous, active-high. Clears state to IDLE. All outputs 0 except req_ready = 1. Latched registers clear to 0. An in-flight memory transaction is abandoned; a late mem_resp_valid in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready = 1. req_valid captures addr, wdata, rd_sel and wr_sel.
  - If the request is a nop (both selects 0), or has an error, the next state is RESP.
  - Otherwise the next state is REQ.
- Error conditions:
  - rd_sel is 110 or 111.
  - rd_sel and wr_sel are both nonzero.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - An errored request never asserts mem_req_valid.
- REQ: mem_req_valid = 1 and the mem_* outputs are stable until mem_req_ready. On mem_req_ready, go to WAIT and clear the timeout counter.
- WAIT: mem_resp_valid is honoured only in WAIT; the memory responds at the earliest one cycle after accept.
  - Loads: format mem_rdata and register it into resp_rdata.
  - Stores: resp_rdata = 0.
  - Then go to RESP.
  - The counter increments each cycle. When it reaches TIMEOUT-1 without a response: resp_err = 1, resp_rdata = 0, go to RESP.
- RESP: resp_valid = 1 with resp_rdata and resp_err held. On resp_ready, go to IDLE. Requests are never accepted in RESP, so there is no back-to-back overlap.
- Latency, counted from the accept cycle (cycle 0):
  - Zero-wait load/store: mem_req_valid in cycle 1, response in cycle 2, resp_valid in cycle 3.
  - Error or nop: resp_valid in cycle 1.
- Store lane placement, with off = addr[1:0]:
  - SB: wdata = {4{wdata[7:0]}}, wmask = 0001 << off.
  - SH: wdata = {2{wdata[15:0]}}, wmask = 0011 << off.
  - SW: wmask = 1111.
  - Loads: wmask = 0000, wen = 0.
- Load extraction:
  - Byte: mem_rdata[8*off +: 8], sign-extended (LB) or zero-extended (LBU).
  - Half: mem_rdata[8*off +: 16] with off in {0, 2}, sign-extended (LH) or zero-extended (LHU).
  - LW: full word.

Decomposition:
- Package ysyx_lsu_pkg:
  - Rd_sel/wr_sel encoding localparams (LB..LW, SB..SW).
  - FSM state enum.
  - TIMEOUT counter width = $clog2(TIMEOUT).
- Sub-module ysyx_lsu_align, purely combinational:
  - Misalign/illegal detect.
  - Store lane replication and mask generation.
  - Load byte/half extraction and extension.
- The FSM, latches and timeout counter live in ysyx_lsu.

Test Plan:
- LB, addr 0x80000003, mem_rdata 0x80FF1234, zero wait -> resp_valid in cycle 3, resp_rdata 0xFFFFFF80, err 0.
- LHU, addr 0x80000002, mem_rdata 0xBEEF0000 -> resp_rdata 0x0000BEEF. LH at the same address -> 0xFFFFBEEF.
- SH, addr 0x80000002, wdata 0x0000ABCD -> mem_addr 0x80000000, mem_wdata 0xABCDABCD, mem_wmask 1100, mem_wen 1; resp_rdata 0.
- SW, addr 0x80000001 -> resp_valid in cycle 1, resp_err 1, mem_req_valid never asserted. rd_sel 110 gives the same result.
- mem_req_ready held low 5 cycles and resp_ready held low 3 cycles -> mem_* stable throughout, result held, req_ready 0 until the resp_ready handshake.
- LW with no mem_resp_valid for TIMEOUT cycles -> resp_err 1, rdata 0. Assert rst mid-WAIT -> IDLE next edge, all outputs 0, req_ready 1; stray mem_resp_valid ignored.
